main_store: RTL and testbench

MAIN_STORE -- requirements
Module: main_store

---
 rtl/main_store_if.sv | 21 ++
 rtl/main_store.sv | 114 +++++++++++
 tb/tb_main_store.sv | 130 +++++++++++++
 3 files changed

// File: rtl/main_store_if.sv
// Beat-level bus for main_store: strobe, line address, write enable, and serial data in both directions.
interface main_store_if #(
  parameter int ADDR_BITS = 5
);
  logic                 w_XTB;
  logic [ADDR_BITS-1:0] b_LINE_ADDR;
  logic                 w_S_WRITE_EN;
  logic                 w_S_DATA_IN;
  logic                 w_S_DATA_OUT;
  logic                 w_S_BUSY;

  modport master (
    output w_XTB, b_LINE_ADDR, w_S_WRITE_EN, w_S_DATA_IN,
    input  w_S_DATA_OUT, w_S_BUSY
  );

  modport slave (
    input  w_XTB, b_LINE_ADDR, w_S_WRITE_EN, w_S_DATA_IN,
    output w_S_DATA_OUT, w_S_BUSY
  );
endinterface

// File: rtl/main_store.sv
// Serial line store: bit-serial beat access to LINES words of INSTR_BITS bits.
// Define MAIN_STORE_CLEAR_EN to make reset clear every line; otherwise the store survives reset.
//
// state   | meaning
// IDLE    | no beat in progress, output low
// BITS    | streaming read bits out, sampling write bits in
// FLYBACK | post-beat dead time, output low, busy high
module main_store #(
  parameter int INSTR_BITS   = 20,
  parameter int FLYBACK_TIME = 4,
  parameter int LINES        = 32
) (
  input  logic           w_CLK,
  input  logic           w_RST_N,
  main_store_if.slave    bus
);
  localparam int ADDR_BITS = $clog2(LINES);
  localparam int CNT_BITS  = $clog2(INSTR_BITS + FLYBACK_TIME + 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(INSTR_BITS);
  localparam logic [CNT_BITS-1:0] CNT_END  = CNT_BITS'(INSTR_BITS + FLYBACK_TIME);

  typedef enum logic [1:0] {IDLE, BITS, FLYBACK} state_t;

  state_t                 state_q;
  logic [CNT_BITS-1:0]    cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   we_q;
  logic [INSTR_BITS-1:0]  rd_q;
  logic [INSTR_BITS-1:0]  wr_q;
  logic                   dout_q;
  logic                   busy_q;
  logic [INSTR_BITS-1:0]  mem_q [LINES];

  logic                   commit;
  logic [INSTR_BITS-1:0]  commit_word;

  // The last write bit arrives on the commit edge itself, so it bypasses wr_q.
  assign commit      = (state_q == BITS) && (cnt_q == CNT_LAST) && we_q;
  assign commit_word = {bus.w_S_DATA_IN, wr_q[INSTR_BITS-2:0]};

  assign bus.w_S_DATA_OUT = dout_q;
  assign bus.w_S_BUSY     = busy_q;

  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.w_XTB) begin
      // Snapshot the whole line so a same-beat write cannot disturb the read stream.
      state_q <= BITS;
      cnt_q   <= CNT_ONE;
      addr_q  <= bus.b_LINE_ADDR;
      we_q    <= bus.w_S_WRITE_EN;
      rd_q    <= mem_q[bus.b_LINE_ADDR];
      dout_q  <= mem_q[bus.b_LINE_ADDR][0];
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          busy_q <= 1'b0;
        end
        BITS: begin
          wr_q[cnt_q - CNT_ONE] <= bus.w_S_DATA_IN;
          cnt_q                 <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= FLYBACK;
            dout_q  <= 1'b0;
          end else begin
            dout_q  <= rd_q[cnt_q];
          end
        end
        FLYBACK: begin
          dout_q <= 1'b0;
          if (cnt_q == CNT_END) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAIN_STORE_CLEAR_EN
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      for (int i = 0; i < LINES; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[addr_q] <= commit_word;
    end
  end
`else
  always_ff @(posedge w_CLK) begin
    if (commit) mem_q[addr_q] <= commit_word;
  end
`endif

endmodule

// File: tb/tb_main_store.sv
// Directed bench for main_store: write/read beats, abort, back-to-back, mid-beat reset, boundary lines.
module tb_main_store;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  main_store_if #(.ADDR_BITS(5)) bus ();

  main_store dut (
    .w_CLK   (clk),
    .w_RST_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one beat. Returns early after edge E(stop_at-1) so the caller can
  // start a new beat whose E0 is edge E(stop_at) of this one.
  task automatic beat(input logic [4:0] addr, input logic we, input logic [19:0] wdata,
                      input logic chk_rd, input logic [19:0] exp_rd,
                      input int stop_at, input string tag);
    logic [19:0] got;
    got = '0;
    bus.w_XTB        = 1'b1;
    bus.b_LINE_ADDR  = addr;
    bus.w_S_WRITE_EN = we;
    tick();
    bus.w_XTB        = 1'b0;
    bus.w_S_WRITE_EN = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k < 20) begin
        got[k] = bus.w_S_DATA_OUT;
        bus.w_S_DATA_IN = wdata[k];
        chk({tag, " busy_bits"}, bus.w_S_BUSY, 1);
      end else if (k < 24) begin
        chk({tag, " out_flyback"}, bus.w_S_DATA_OUT, 0);
        chk({tag, " busy_flyback"}, bus.w_S_BUSY, 1);
      end else begin
        chk({tag, " out_idle"}, bus.w_S_DATA_OUT, 0);
        chk({tag, " busy_idle"}, bus.w_S_BUSY, 0);
      end
      if (k == 19 && chk_rd) chk({tag, " word"}, got, exp_rd);
      if (k == stop_at - 1) return;
      if (k < 24) tick();
    end
  endtask

  logic [19:0] exp9;

  initial begin
    bus.w_XTB        = 1'b0;
    bus.b_LINE_ADDR  = '0;
    bus.w_S_WRITE_EN = 1'b0;
    bus.w_S_DATA_IN  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out", bus.w_S_DATA_OUT, 0);
    chk("reset busy", bus.w_S_BUSY, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset out", bus.w_S_DATA_OUT, 0);
    chk("post_reset busy", bus.w_S_BUSY, 0);

    // Serial write then read back; LSB-first stream of 0x5A3C1.
    beat(5'd5, 1'b1, 20'h5A3C1, 1'b0, 20'h0, 0, "wr5");
    beat(5'd5, 1'b0, 20'h0, 1'b1, 20'h5A3C1, 0, "rd5");

    // Read-during-write streams the old contents.
    beat(5'd7, 1'b1, 20'h00001, 1'b0, 20'h0, 0, "wr7_init");
    beat(5'd7, 1'b1, 20'hFFFFF, 1'b1, 20'h00001, 0, "rdw7");
    beat(5'd7, 1'b0, 20'h0, 1'b1, 20'hFFFFF, 0, "rd7");

    // Abort: strobe sampled at E10 of a write beat, no commit.
    beat(5'd3, 1'b1, 20'h12345, 1'b0, 20'h0, 0, "wr3_init");
    beat(5'd3, 1'b1, 20'hABCDE, 1'b0, 20'h0, 10, "abort_wr3");
    beat(5'd3, 1'b0, 20'h0, 1'b1, 20'h12345, 0, "abort_rd3");

    // Back-to-back: next strobe sampled at E24, commit retained.
    beat(5'd10, 1'b1, 20'h0F0F0, 1'b0, 20'h0, 24, "b2b_wr10");
    beat(5'd10, 1'b0, 20'h0, 1'b1, 20'h0F0F0, 0, "b2b_rd10");

    // Boundary lines, then confirm untouched lines kept their values.
    beat(5'd0, 1'b1, 20'hFFFFF, 1'b0, 20'h0, 0, "wr0");
    beat(5'd31, 1'b1, 20'h00000, 1'b0, 20'h0, 0, "wr31");
    beat(5'd0, 1'b0, 20'h0, 1'b1, 20'hFFFFF, 0, "rd0");
    beat(5'd31, 1'b0, 20'h0, 1'b1, 20'h00000, 0, "rd31");
    beat(5'd5, 1'b0, 20'h0, 1'b1, 20'h5A3C1, 0, "keep5");
    beat(5'd3, 1'b0, 20'h0, 1'b1, 20'h12345, 0, "keep3");
    beat(5'd10, 1'b0, 20'h0, 1'b1, 20'h0F0F0, 0, "keep10");

    // Reset after E12 of a write beat on line 9 (bit 12 of 0x13579 is 1).
    beat(5'd9, 1'b1, 20'h13579, 1'b0, 20'h0, 0, "wr9_init");
    beat(5'd9, 1'b1, 20'hFFFFF, 1'b0, 20'h0, 13, "rst_wr9");
    chk("rst pre out", bus.w_S_DATA_OUT, 1);
    rst_n = 1'b0;
    #1;
    chk("rst mid out", bus.w_S_DATA_OUT, 0);
    chk("rst mid busy", bus.w_S_BUSY, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst release busy", bus.w_S_BUSY, 0);
`ifdef MAIN_STORE_CLEAR_EN
    exp9 = 20'h00000;
`else
    exp9 = 20'h13579;
`endif
    beat(5'd9, 1'b0, 20'h0, 1'b1, exp9, 0, "rst_rd9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
